// File: rtl/ss_ram_arbiter.sv
// ss_ram_arbiter: shares one single-port RAM between a read-data engine
// (requester 0) and a write-data engine (requester 1). A registered grant FSM
// arbitrates round-robin on contention and forces a handoff after MAX_BURST
// consecutive cycles when the other side is waiting. The owner's access is
// muxed onto the RAM port and read data is returned to whoever issued the read.
module ss_ram_arbiter #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_0,
  input  logic                 i_we_0,
  input  logic [SIZE_ADDR-1:0] i_addr_0,
  input  logic [SIZE_DATA-1:0] i_data_0,
  input  logic                 i_req_1,
  input  logic                 i_we_1,
  input  logic [SIZE_ADDR-1:0] i_addr_1,
  input  logic [SIZE_DATA-1:0] i_data_1,
  output logic                 o_gnt_0,
  output logic                 o_gnt_1,
  output logic                 o_rvalid_0,
  output logic                 o_rvalid_1,
  output logic [SIZE_DATA-1:0] o_rdata,
  output logic                 o_en_ram,
  output logic                 o_we_ram,
  output logic [SIZE_ADDR-1:0] o_addr_ram,
  output logic [SIZE_DATA-1:0] o_data_ram,
  input  logic [SIZE_DATA-1:0] i_data_ram
);

  // One extra bit keeps MAX_BURST = 1 legal (a 1-bit counter pinned at 0).
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;
  logic             last_owner;
  logic             last_owner_nxt;
  logic             burst_done;
  logic             rd_strobe;
  logic             rvalid_0_q;
  logic             rvalid_1_q;

  // The owner has used its full burst allowance; only matters under contention.
  assign burst_done = (burst_cnt == CNT_LAST);

  // Next-state decision: round-robin from IDLE, handoff on release or preemption.
  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_req_0 && i_req_1) begin
          // Tie goes to the side that did not own the port most recently.
          state_nxt = last_owner ? GNT0 : GNT1;
        end else if (i_req_0) begin
          state_nxt = GNT0;
        end else if (i_req_1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!i_req_0) begin
          state_nxt = i_req_1 ? GNT1 : IDLE;
        end else if (burst_done && i_req_1) begin
          state_nxt = GNT1;
        end
      end
      GNT1: begin
        if (!i_req_1) begin
          state_nxt = i_req_0 ? GNT0 : IDLE;
        end else if (burst_done && i_req_0) begin
          state_nxt = GNT0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst length tracking and round-robin memory for the next tie.
  always_comb begin
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    if (state_nxt != state) begin
      burst_cnt_nxt = '0;
      if (state_nxt == GNT0) begin
        last_owner_nxt = 1'b0;
      end else if (state_nxt == GNT1) begin
        last_owner_nxt = 1'b1;
      end
    end else if (state != IDLE && !burst_done) begin
      // Saturates at the last burst slot so an uncontended owner keeps the
      // port indefinitely, yet yields on the first cycle the other side asks.
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end
  end

  // Grant FSM state register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Grants are decoded from the state register alone, never from requests.
  assign o_gnt_0 = (state == GNT0);
  assign o_gnt_1 = (state == GNT1);

  // RAM port mux: only the owner drives the port, and only while it requests.
  always_comb begin
    o_en_ram   = 1'b0;
    o_we_ram   = 1'b0;
    o_addr_ram = '0;
    o_data_ram = '0;
    case (state)
      GNT0: begin
        if (i_req_0) begin
          o_en_ram   = 1'b1;
          o_we_ram   = i_we_0;
          o_addr_ram = i_addr_0;
          o_data_ram = i_data_0;
        end
      end
      GNT1: begin
        if (i_req_1) begin
          o_en_ram   = 1'b1;
          o_we_ram   = i_we_1;
          o_addr_ram = i_addr_1;
          o_data_ram = i_data_1;
        end
      end
      default: begin
      end
    endcase
  end

  assign rd_strobe = o_en_ram & ~o_we_ram;

  // Read-return tag, captured in the issuing cycle so a read made just before
  // a handoff still returns to the side that issued it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
    end else begin
      rvalid_0_q <= rd_strobe & (state == GNT0);
      rvalid_1_q <= rd_strobe & (state == GNT1);
    end
  end

  assign o_rvalid_0 = rvalid_0_q;
  assign o_rvalid_1 = rvalid_1_q;

  // The RAM's output register already holds the word in the cycle after the
  // strobe; forward it only while a tag is valid so idle cycles and the
  // post-reset state present zero.
  assign o_rdata = (rvalid_0_q | rvalid_1_q) ? i_data_ram : '0;

endmodule

// File: tb/tb_ss_ram_arbiter.sv
// Self-checking bench for ss_ram_arbiter. Two instances (MAX_BURST 16 and 1)
// share stimulus; each has its own RAM and a cycle-level reference model of
// the ownership rules. Directed sequences, a vector table and random bursts.
module tb_ss_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       preload;
  logic       req_0, we_0, req_1, we_1;
  logic [5:0] addr_0, addr_1;
  logic [7:0] data_0, data_1;

  logic [1:0] gnt_0, gnt_1, rvalid_0, rvalid_1, en_ram, we_ram;
  logic [7:0] rdata    [2];
  logic [5:0] addr_ram [2];
  logic [7:0] data_ram [2];
  logic [7:0] ram_q    [2];
  logic [7:0] ram      [2][64];

  ss_ram_arbiter #(.SIZE_ADDR(6), .SIZE_DATA(8), .MAX_BURST(16)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_0(req_0), .i_we_0(we_0), .i_addr_0(addr_0), .i_data_0(data_0),
    .i_req_1(req_1), .i_we_1(we_1), .i_addr_1(addr_1), .i_data_1(data_1),
    .o_gnt_0(gnt_0[0]), .o_gnt_1(gnt_1[0]),
    .o_rvalid_0(rvalid_0[0]), .o_rvalid_1(rvalid_1[0]), .o_rdata(rdata[0]),
    .o_en_ram(en_ram[0]), .o_we_ram(we_ram[0]), .o_addr_ram(addr_ram[0]),
    .o_data_ram(data_ram[0]), .i_data_ram(ram_q[0])
  );

  ss_ram_arbiter #(.SIZE_ADDR(6), .SIZE_DATA(8), .MAX_BURST(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_0(req_0), .i_we_0(we_0), .i_addr_0(addr_0), .i_data_0(data_0),
    .i_req_1(req_1), .i_we_1(we_1), .i_addr_1(addr_1), .i_data_1(data_1),
    .o_gnt_0(gnt_0[1]), .o_gnt_1(gnt_1[1]),
    .o_rvalid_0(rvalid_0[1]), .o_rvalid_1(rvalid_1[1]), .o_rdata(rdata[1]),
    .o_en_ram(en_ram[1]), .o_we_ram(we_ram[1]), .o_addr_ram(addr_ram[1]),
    .o_data_ram(data_ram[1]), .i_data_ram(ram_q[1])
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) % 256);
  endfunction

  // Single-port RAM with registered read output, one per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        for (int a = 0; a < 64; a++) ram[k][a] <= init_val(a);
      end else if (en_ram[k]) begin
        if (we_ram[k]) ram[k][addr_ram[k]] <= data_ram[k];
        else           ram_q[k] <= ram[k][addr_ram[k]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: owner -1 = nobody, run = cycles owned so far (1-based).
  int         m_owner [2];
  int         m_run   [2];
  int         m_last  [2];
  int         m_pend  [2];
  logic [7:0] m_pdata [2];
  logic [7:0] ref_mem [2][64];
  bit         m_ok;

  task automatic model_cycle(input int k);
    int mb, o, n;
    bit rq[2];
    bit wq[2];
    logic [5:0] aq[2];
    logic [7:0] dq[2];
    bit e_en, e_we;
    logic [5:0] e_addr;
    logic [7:0] e_data;
    string tag;
    mb = (k == 0) ? 16 : 1;
    tag = (k == 0) ? "mb16" : "mb1";
    rq[0] = req_0; wq[0] = we_0; aq[0] = addr_0; dq[0] = data_0;
    rq[1] = req_1; wq[1] = we_1; aq[1] = addr_1; dq[1] = data_1;
    o = m_owner[k];
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
    if (o >= 0 && rq[o]) begin
      e_en = 1'b1; e_we = wq[o]; e_addr = aq[o]; e_data = dq[o];
    end
    if (m_ok) begin
      check({tag, ".gnt_0"},    gnt_0[k],    o == 0);
      check({tag, ".gnt_1"},    gnt_1[k],    o == 1);
      check({tag, ".en_ram"},   en_ram[k],   e_en);
      check({tag, ".we_ram"},   we_ram[k],   e_we);
      check({tag, ".addr_ram"}, addr_ram[k], e_addr);
      check({tag, ".data_ram"}, data_ram[k], e_data);
      check({tag, ".rvalid_0"}, rvalid_0[k], m_pend[k] == 0);
      check({tag, ".rvalid_1"}, rvalid_1[k], m_pend[k] == 1);
      if (m_pend[k] >= 0) check({tag, ".rdata"}, rdata[k], m_pdata[k]);
    end
    if (e_we) ref_mem[k][e_addr] = e_data;
    if (rst) begin
      m_owner[k] = -1; m_run[k] = 0; m_last[k] = 1; m_pend[k] = -1;
    end else begin
      m_pend[k] = (e_en && !e_we) ? o : -1;
      if (e_en && !e_we) m_pdata[k] = ref_mem[k][e_addr];
      if (o < 0) begin
        if (rq[0] && rq[1]) n = 1 - m_last[k];
        else if (rq[0])     n = 0;
        else if (rq[1])     n = 1;
        else                n = -1;
      end else if (!rq[o]) begin
        n = rq[1-o] ? 1 - o : -1;
      end else if (m_run[k] >= mb && rq[1-o]) begin
        n = 1 - o;
      end else begin
        n = o;
      end
      if (n != o) begin
        m_owner[k] = n;
        m_run[k] = (n >= 0) ? 1 : 0;
        if (n >= 0) m_last[k] = n;
      end else if (n >= 0) begin
        m_run[k]++;
      end
    end
  endtask

  // Compare at the falling edge, then step to just after the rising edge.
  task automatic sample();
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_0 = 0; we_0 = 0; addr_0 = '0; data_0 = '0;
    req_1 = 0; we_1 = 0; addr_1 = '0; data_1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    sample(); advance();
    rst = 0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) begin sample(); advance(); end
  endtask

  // Requester 0 alone reads n words from base on dut0 (starting from IDLE).
  logic [7:0] got [16];
  task automatic read_run(input string name, input int base, input int n);
    for (int c = 0; c <= n + 2; c++) begin
      req_0 = (c <= n); we_0 = 0; data_0 = '0;
      addr_0 = 6'(base + ((c >= 1) ? c - 1 : 0));
      sample();
      check({name, ".gnt_0"}, gnt_0[0], (c >= 1 && c <= n + 1));
      check({name, ".en_ram"}, en_ram[0], (c >= 1 && c <= n));
      if (c >= 1 && c <= n) check({name, ".addr_ram"}, addr_ram[0], 6'(base + c - 1));
      check({name, ".rvalid_0"}, rvalid_0[0], (c >= 2 && c <= n + 1));
      check({name, ".rvalid_1"}, rvalid_1[0], 1'b0);
      if (c >= 2 && c <= n + 1) got[c-2] = rdata[0];
      advance();
    end
    req_0 = 0;
  endtask

  typedef struct {
    logic r0, w0; logic [5:0] a0; logic [7:0] d0;
    logic r1, w1; logic [5:0] a1; logic [7:0] d1;
    logic g0, g1, en, we; logic [5:0] addr; logic [7:0] dat; logic rv0;
  } vec_t;
  vec_t tbl [11];

  int left [2];
  bit on [2];

  initial begin
    // Tie from IDLE, requester 0 reads 3 words then releases, requester 1 writes.
    tbl[0]  = '{1, 0, 20, 8'h00, 1, 1, 0, 8'h10, 0, 0, 0, 0,  0, 8'h00, 0};
    tbl[1]  = '{1, 0, 20, 8'h00, 1, 1, 0, 8'h10, 1, 0, 1, 0, 20, 8'h00, 0};
    tbl[2]  = '{1, 0, 21, 8'h00, 1, 1, 0, 8'h10, 1, 0, 1, 0, 21, 8'h00, 1};
    tbl[3]  = '{1, 0, 22, 8'h00, 1, 1, 0, 8'h10, 1, 0, 1, 0, 22, 8'h00, 1};
    tbl[4]  = '{0, 0,  0, 8'h00, 1, 1, 0, 8'h10, 1, 0, 0, 0,  0, 8'h00, 1};
    tbl[5]  = '{0, 0,  0, 8'h00, 1, 1, 0, 8'h10, 0, 1, 1, 1,  0, 8'h10, 0};
    tbl[6]  = '{0, 0,  0, 8'h00, 1, 1, 1, 8'h11, 0, 1, 1, 1,  1, 8'h11, 0};
    tbl[7]  = '{0, 0,  0, 8'h00, 1, 1, 2, 8'h12, 0, 1, 1, 1,  2, 8'h12, 0};
    tbl[8]  = '{0, 0,  0, 8'h00, 1, 1, 3, 8'h13, 0, 1, 1, 1,  3, 8'h13, 0};
    tbl[9]  = '{0, 0,  0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0,  0, 8'h00, 0};
    tbl[10] = '{0, 0,  0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 0};

    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_run[k] = 0; m_last[k] = 1; m_pend[k] = -1; m_pdata[k] = '0;
      for (int a = 0; a < 64; a++) ref_mem[k][a] = init_val(a);
    end
    m_ok = 0;
    clear_inputs();
    rst = 1; preload = 1;
    advance();
    preload = 0; m_ok = 1;
    sample(); advance();
    rst = 0;

    // Reset state.
    sample();
    check("rst.gnt_0", gnt_0[0], 1'b0);
    check("rst.gnt_1", gnt_1[0], 1'b0);
    check("rst.rvalid_0", rvalid_0[0], 1'b0);
    check("rst.rvalid_1", rvalid_1[0], 1'b0);
    check("rst.rdata", rdata[0], 8'h00);
    check("rst.en_ram", en_ram[0], 1'b0);
    check("rst.we_ram", we_ram[0], 1'b0);
    check("rst.addr_ram", addr_ram[0], 6'd0);
    check("rst.data_ram", data_ram[0], 8'h00);
    advance();

    // Test 1: lone reader, addresses 5..8.
    read_run("t1", 5, 4);
    for (int i = 0; i < 4; i++) check("t1.rdata", got[i], init_val(5 + i));

    // Test 2: vector table, then read back what requester 1 wrote.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req_0 = tbl[i].r0; we_0 = tbl[i].w0; addr_0 = tbl[i].a0; data_0 = tbl[i].d0;
      req_1 = tbl[i].r1; we_1 = tbl[i].w1; addr_1 = tbl[i].a1; data_1 = tbl[i].d1;
      sample();
      check("t2.gnt_0", gnt_0[0], tbl[i].g0);
      check("t2.gnt_1", gnt_1[0], tbl[i].g1);
      check("t2.en_ram", en_ram[0], tbl[i].en);
      check("t2.we_ram", we_ram[0], tbl[i].we);
      check("t2.addr_ram", addr_ram[0], tbl[i].addr);
      check("t2.data_ram", data_ram[0], tbl[i].dat);
      check("t2.rvalid_0", rvalid_0[0], tbl[i].rv0);
      check("t2.rvalid_1", rvalid_1[0], 1'b0);
      advance();
    end
    read_run("t2rb", 0, 4);
    for (int i = 0; i < 4; i++) check("t2.readback", got[i], 8'(8'h10 + i));

    // Tests 3 and 4: continuous contention, blocks of 16 on dut0, alternation on dut1.
    do_reset();
    for (int c = 0; c <= 66; c++) begin
      req_0 = 1; we_0 = 0; addr_0 = 6'(c); data_0 = '0;
      req_1 = 1; we_1 = 0; addr_1 = 6'(c + 32); data_1 = '0;
      sample();
      check("t3.gnt_0", gnt_0[0], (c >= 1 && ((c - 1) / 16) % 2 == 0));
      check("t3.gnt_1", gnt_1[0], (c >= 1 && ((c - 1) / 16) % 2 == 1));
      check("t3.rvalid_0", rvalid_0[0], (c >= 2 && ((c - 2) / 16) % 2 == 0));
      if (c >= 1) check("t3.burst_cnt", dut0.burst_cnt, (c - 1) % 16);
      check("t4.gnt_0", gnt_0[1], (c >= 1 && (c - 1) % 2 == 0));
      check("t4.gnt_1", gnt_1[1], (c >= 1 && (c - 1) % 2 == 1));
      check("t4.rvalid_0", rvalid_0[1], (c >= 2 && (c - 2) % 2 == 0));
      check("t4.rvalid_1", rvalid_1[1], (c >= 2 && (c - 2) % 2 == 1));
      advance();
    end
    idle(2);

    // Test 5: read of addr 9 in the last slot before handoff to a writer.
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      req_0 = (c <= 16); we_0 = 0; addr_0 = (c == 16) ? 6'd9 : 6'd40; data_0 = '0;
      req_1 = 1; we_1 = 1; addr_1 = 6'd50; data_1 = 8'hA5;
      sample();
      if (c == 16) begin
        check("t5.gnt_0", gnt_0[0], 1'b1);
        check("t5.addr_ram", addr_ram[0], 6'd9);
        check("t5.we_ram", we_ram[0], 1'b0);
      end
      if (c == 17) begin
        check("t5.gnt_1", gnt_1[0], 1'b1);
        check("t5.gnt_0_low", gnt_0[0], 1'b0);
        check("t5.we_ram", we_ram[0], 1'b1);
        check("t5.rvalid_0", rvalid_0[0], 1'b1);
        check("t5.rdata", rdata[0], init_val(9));
        check("t5.rvalid_1", rvalid_1[0], 1'b0);
      end
      advance();
    end
    idle(2);

    // Test 6: reset mid-burst while requester 1 writes 8..12.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      int a;
      case (c)
        0, 1:    a = 8;
        2:       a = 9;
        3, 4, 5: a = 10;
        6:       a = 11;
        7:       a = 12;
        default: a = 0;
      endcase
      req_1 = (c <= 7); we_1 = 1; addr_1 = 6'(a); data_1 = 8'(8'h80 + a);
      rst = (c == 3);
      sample();
      if (c == 3) begin
        check("t6.gnt_1_pre", gnt_1[0], 1'b1);
        check("t6.addr_pre", addr_ram[0], 6'd10);
      end
      if (c == 4) begin
        check("t6.gnt_0", gnt_0[0], 1'b0);
        check("t6.gnt_1", gnt_1[0], 1'b0);
        check("t6.en_ram", en_ram[0], 1'b0);
        check("t6.we_ram", we_ram[0], 1'b0);
        check("t6.addr_ram", addr_ram[0], 6'd0);
        check("t6.data_ram", data_ram[0], 8'h00);
        check("t6.rvalid_0", rvalid_0[0], 1'b0);
        check("t6.rvalid_1", rvalid_1[0], 1'b0);
        check("t6.rdata", rdata[0], 8'h00);
      end
      if (c == 5) begin
        check("t6.gnt_1_resume", gnt_1[0], 1'b1);
        check("t6.we_resume", we_ram[0], 1'b1);
        check("t6.addr_resume", addr_ram[0], 6'd10);
      end
      advance();
    end
    rst = 0;
    read_run("t6rb", 8, 5);
    for (int i = 0; i < 5; i++) check("t6.readback", got[i], 8'(8'h88 + i));

    // Random bursts against the reference model, with rare resets.
    left[0] = 0; left[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (left[r] == 0) begin
          left[r] = $urandom_range(1, 40);
          on[r] = ($urandom_range(0, 2) != 0);
        end
      end
      req_0 = on[0]; we_0 = 1'($urandom_range(0, 1)); addr_0 = 6'($urandom); data_0 = 8'($urandom);
      req_1 = on[1]; we_1 = 1'($urandom_range(0, 1)); addr_1 = 6'($urandom); data_1 = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      sample();
      advance();
      left[0]--; left[1]--;
    end
    rst = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
